// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive path (uart_rx, uart_rx_fifo).
// Holds default character format, FIFO parameter checks and the drop counter width.
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_OVERSAMPLING = 16;
   localparam int DROP_CNT_W        = 8;

   // FIFO pointers wrap by natural overflow, so the depth must be a power of two.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_BITS register array: synchronous write, asynchronous read.
// Storage only; pointer and occupancy logic belong to the instantiating FIFO.
module uart_fifo_ram #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk_in,
   input  logic                 wr_en_in,
   input  logic [AW-1:0]        wr_addr_in,
   input  logic [DATA_BITS-1:0] wr_data_in,
   input  logic [AW-1:0]        rd_addr_in,
   output logic [DATA_BITS-1:0] rd_data_out
);

   logic [DATA_BITS-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; occupancy is tracked outside, so stale
   // contents are never presented as valid and a reset would only cost logic.
   always_ff @(posedge clk_in) begin
      if (wr_en_in) begin
         mem_q[wr_addr_in] <= wr_data_in;
      end
   end

   assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver with level, almost-full and
// sticky overrun status. Define UART_RX_FIFO_STATS_EN to add drop_cnt_out.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS       = UART_DATA_BITS,
   parameter int DEPTH           = 16,
   parameter int ALMOST_FULL_LVL = 12
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       wr_valid_in,
   input  logic [DATA_BITS-1:0]       wr_data_in,
   output logic                       rd_valid_out,
   input  logic                       rd_ready_in,
   output logic [DATA_BITS-1:0]       rd_data_out,
   output logic [$clog2(DEPTH):0]     level_out,
   output logic                       almost_full_out,
   output logic                       overrun_out,
   input  logic                       overrun_clr_in
`ifdef UART_RX_FIFO_STATS_EN
   ,
   output logic [DROP_CNT_W-1:0]      drop_cnt_out
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!depth_ok(DEPTH) || ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > DEPTH) begin : g_bad_params
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and ALMOST_FULL_LVL in 1..DEPTH");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rd_valid_q, rd_valid_d;
   logic          almost_full_q, almost_full_d;
   logic          overrun_q, overrun_d;
   logic          wr_valid_q, wr_valid_d;

   logic     push, pop, full, wr_en, drop;
   fifo_op_e op;

   // NOTE: every signal assigned here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      push  = wr_valid_in & ~wr_valid_q;
      pop   = rd_valid_q & rd_ready_in;
      full  = (count_q == CW'(DEPTH));
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;
      op    = fifo_op_e'({pop, wr_en});

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wr_valid_d = wr_valid_in;

      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

      case (op)
         OP_PUSH: count_d = count_q + CW'(1);
         OP_POP:  count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      rd_valid_d    = (count_d != '0);
      almost_full_d = (count_d >= CW'(ALMOST_FULL_LVL));
      overrun_d     = drop | (overrun_q & ~overrun_clr_in);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         rd_valid_q    <= 1'b0;
         almost_full_q <= 1'b0;
         overrun_q     <= 1'b0;
         // Held high so a character pending across reset is not captured.
         wr_valid_q    <= 1'b1;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         rd_valid_q    <= rd_valid_d;
         almost_full_q <= almost_full_d;
         overrun_q     <= overrun_d;
         wr_valid_q    <= wr_valid_d;
      end
   end

   uart_fifo_ram #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_ram (
      .clk_in      (clk_in),
      .wr_en_in    (wr_en),
      .wr_addr_in  (wr_ptr_q),
      .wr_data_in  (wr_data_in),
      .rd_addr_in  (rd_ptr_q),
      .rd_data_out (rd_data_out)
   );

   assign rd_valid_out    = rd_valid_q;
   assign level_out       = count_q;
   assign almost_full_out = almost_full_q;
   assign overrun_out     = overrun_q;

`ifdef UART_RX_FIFO_STATS_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Clear applies first, so a drop in the clearing cycle leaves a count of one.
   always_comb begin
      drop_cnt_d = overrun_clr_in ? '0 : drop_cnt_q;
      if (drop && (drop_cnt_d != '1)) begin
         drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, DATA_BITS=8): a vector table for
// basic push/pop behaviour plus hand-written fill, overrun and reset sequences.
module tb_uart_rx_fifo;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic       wr_valid_in = 1'b0;
   logic [7:0] wr_data_in = '0;
   logic       rd_valid_out;
   logic       rd_ready_in = 1'b0;
   logic [7:0] rd_data_out;
   logic [4:0] level_out;
   logic       almost_full_out;
   logic       overrun_out;
   logic       overrun_clr_in = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
   logic [7:0] drop_cnt_out;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_in = ~clk_in;

   uart_rx_fifo #(
      .DATA_BITS       (8),
      .DEPTH           (16),
      .ALMOST_FULL_LVL (12)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .wr_valid_in     (wr_valid_in),
      .wr_data_in      (wr_data_in),
      .rd_valid_out    (rd_valid_out),
      .rd_ready_in     (rd_ready_in),
      .rd_data_out     (rd_data_out),
      .level_out       (level_out),
      .almost_full_out (almost_full_out),
      .overrun_out     (overrun_out),
      .overrun_clr_in  (overrun_clr_in)
`ifdef UART_RX_FIFO_STATS_EN
      ,
      .drop_cnt_out    (drop_cnt_out)
`endif
   );

   typedef struct {
      logic       rst;
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       clr;
      logic       e_rv;
      logic       chk_data;
      logic [7:0] e_data;
      logic [4:0] e_lvl;
      logic       e_af;
      logic       e_ovr;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle, then sample 1 time unit after the rising edge.
   task automatic step(input logic rst, input logic wv, input logic [7:0] wd,
                       input logic rr, input logic clr);
      rst_in         = rst;
      wr_valid_in    = wv;
      wr_data_in     = wd;
      rd_ready_in    = rr;
      overrun_clr_in = clr;
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_status(input string tag, input logic rv, input logic [4:0] lvl,
                               input logic af, input logic ovr);
      check({tag, ".rd_valid"}, 32'(rd_valid_out), 32'(rv));
      check({tag, ".level"}, 32'(level_out), 32'(lvl));
      check({tag, ".almost_full"}, 32'(almost_full_out), 32'(af));
      check({tag, ".overrun"}, 32'(overrun_out), 32'(ovr));
   endtask

   task automatic push_one(input logic [7:0] d);
      step(1'b0, 1'b1, d, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_q[$];

      //            rst  wv   wd     rr   clr  e_rv chk  e_data e_lvl af   ovr
      vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

      @(negedge clk_in);
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].clr);
         check_status($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_lvl,
                      vecs[i].e_af, vecs[i].e_ovr);
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d.rd_data", i), 32'(rd_data_out), 32'(vecs[i].e_data));
         end
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Fill to DEPTH; almost_full rises once the level reaches 12.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
         check_status($sformatf("fill%0d", i), 1'b1, 5'(i + 1), (i + 1) >= 12, 1'b0);
         check($sformatf("fill%0d.head", i), 32'(rd_data_out), 32'h00);
         step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      end

      step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
      check_status("drop", 1'b1, 5'd16, 1'b1, 1'b1);
      check("drop.head", 32'(rd_data_out), 32'h00);
`ifdef UART_RX_FIFO_STATS_EN
      check("drop.cnt", 32'(drop_cnt_out), 32'd1);
`endif
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_status("clr", 1'b1, 5'd16, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
      check("clr.cnt", 32'(drop_cnt_out), 32'd0);
`endif

      // Push and pop together while full: no drop, level stays at DEPTH.
      step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
      check_status("full_pp", 1'b1, 5'd16, 1'b1, 1'b0);
      check("full_pp.head", 32'(rd_data_out), 32'h01);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h55);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("drain%0d.data", k), 32'(rd_data_out), 32'(exp_q[k]));
         check($sformatf("drain%0d.level", k), 32'(level_out), 32'(16 - k));
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_status("drained", 1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Clear coinciding with a fresh overrun: set wins.
      for (int i = 0; i < 16; i++) push_one(8'h20 + 8'(i));
      check_status("refill", 1'b1, 5'd16, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
      check_status("drop2", 1'b1, 5'd16, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
      check_status("drop_clr", 1'b1, 5'd16, 1'b1, 1'b1);
      check("drop_clr.head", 32'(rd_data_out), 32'h20);
`ifdef UART_RX_FIFO_STATS_EN
      check("drop_clr.cnt", 32'(drop_cnt_out), 32'd1);
`endif
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_status("clr2", 1'b1, 5'd16, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
      check("clr2.cnt", 32'(drop_cnt_out), 32'd0);
`endif

      // Reset while full, then reset with wr_valid_in held high over 3 entries.
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check_status("rst_full", 1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      push_one(8'h61);
      push_one(8'h62);
      push_one(8'h63);
      check_status("three", 1'b1, 5'd3, 1'b0, 1'b0);
      check("three.head", 32'(rd_data_out), 32'h61);
      step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
      check_status("rst_mid", 1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      check_status("post_rst_hold0", 1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      check_status("post_rst_hold1", 1'b0, 5'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      check_status("recapture", 1'b1, 5'd1, 1'b0, 1'b0);
      check("recapture.head", 32'(rd_data_out), 32'h77);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
